blake2_msg_sched: RTL and testbench
===================================

BLAKE2_MSG_SCHED -- requirements
Module: blake2_msg_sched

Interface
REQ-001 Parameter WORD_W, default 32, message word width in bits; legal values 32 (BLAKE2s) and 64 (BLAKE2b).
REQ-002 Parameter NUM_ROUNDS, default 10, rounds per block; legal range 1..16 (10 for BLAKE2s, 12 for BLAKE2b).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 load_valid  input  1  message block offered on m.
REQ-006 load_ready  output  1  block can be accepted (state IDLE).
REQ-007 m  input  16*WORD_W  raw message block; byte 0 is at the MSB end.
REQ-008 abort  input  1  discard the current block and return to IDLE.
REQ-009 out_valid  output  1  a schedule step is presented.
REQ-010 out_ready  input  1  consumer accepts the current step.
REQ-011 out_words  output  8*WORD_W  eight words G0_m0,G0_m1,G1_m0,...,G3_m1, with G0_m0 in the least significant WORD_W bits.
REQ-012 out_round  output  4  round index of the current step.
REQ-013 out_mode  output  1  0 = column step, 1 = diagonal step.
REQ-014 out_last  output  1  current step is the final step of the block.
REQ-015 busy  output  1  high while in state RUN.

Function
REQ-016 The block SHALL have two states: IDLE, with load_ready=1 and out_valid=0, and RUN, with load_ready=0 and out_valid=1.
REQ-017 In IDLE, load_valid=1 SHALL capture m into a 16-entry word store, clear the step counter to 0 and enter RUN on the next edge.
REQ-018 Word k SHALL be loaded little-endian: its least significant byte is m[16*WORD_W-1-k*WORD_W -: 8], and each more significant byte is taken from the next lower byte of m.
REQ-019 Step counter s SHALL be 0..2*NUM_ROUNDS-1, with out_round = s>>1 and out_mode = s[0].
REQ-020 out_words SHALL select words by the BLAKE2 SIGMA table (RFC 7693) at row (out_round mod 10): out_mode=0 uses SIGMA entries 0..7 and out_mode=1 uses entries 8..15, in output order G0_m0..G3_m1.
REQ-021 out_words, out_round, out_mode and out_last SHALL be a function only of registered state and SHALL have no combinational path from any input.
REQ-022 A step SHALL advance only when out_valid and out_ready are both high; while out_ready=0 every output SHALL hold stable.
REQ-023 out_last SHALL be 1 exactly when s = 2*NUM_ROUNDS-1; acceptance of that step SHALL return the block to IDLE with load_ready=1 on the next cycle.
REQ-024 First-step latency SHALL be one cycle: out_valid=1 in the cycle after the load handshake.
REQ-025 The block SHALL provide one step per cycle when out_ready stays high, i.e. 2*NUM_ROUNDS cycles per block.
REQ-026 load_valid in RUN SHALL be ignored, and the word store SHALL remain unchanged.
REQ-027 abort=1 SHALL force IDLE on the next edge and take priority over a simultaneous out handshake; the word store is retained and the step counter cleared.
REQ-028 abort in IDLE SHALL have no effect, and a simultaneous load_valid SHALL NOT be accepted.
REQ-029 For rounds 10 and 11 (BLAKE2b), the SIGMA row SHALL wrap to rows 0 and 1.

Reset
REQ-030 While reset=1, the block SHALL asynchronously clear to: state IDLE, step counter 0, all store words 0.
REQ-031 Output values during reset SHALL be: load_ready=1, out_valid=0, busy=0, out_words=0, out_round=0, out_mode=0, out_last=0.
REQ-032 Reset asserted mid-block SHALL discard the block, with no further out_valid until a new load.

Verification
REQ-033 WORD_W=32, word k = k, out_ready=1: steps 0/1/2 SHALL give words (0..7), (8..15) and (14,10,4,8,9,15,13,6); out_last SHALL be high on step 19; load_ready SHALL be high one cycle later.
REQ-034 WORD_W=64, NUM_ROUNDS=12, word k = k: steps 20/21 SHALL equal steps 0/1, and out_last SHALL be high on step 23.
REQ-035 Byte order: m = 0x00 01 02 ... 3F from the MSB end, WORD_W=32: word 0 SHALL be 0x03020100 and word 15 SHALL be 0x3F3E3D3C.
REQ-036 Backpressure: hold out_ready=0 for 3 cycles at step 5; outputs SHALL be unchanged, and step 6 SHALL appear only after acceptance.
REQ-037 Abort at step 7 together with out_ready=1: the block SHALL return to IDLE next cycle, and a reload SHALL restart at step 0.
REQ-038 Reset asserted at step 4 and released: all outputs SHALL match REQ-031, and a load_valid during RUN before the reset SHALL NOT alter the stored words.

Source files
------------

// File: rtl/blake2_msg_sched_if.sv
// Handshake bundle for the BLAKE2 message scheduler: block load on one side,
// per-step word selection on the other.
interface blake2_msg_sched_if #(
  parameter int WORD_W = 32
);
  logic                   load_valid;
  logic                   load_ready;
  logic [16*WORD_W-1:0]   m;
  logic                   abort;
  logic                   out_valid;
  logic                   out_ready;
  logic [8*WORD_W-1:0]    out_words;
  logic [3:0]             out_round;
  logic                   out_mode;
  logic                   out_last;
  logic                   busy;

  modport master (
    output load_valid, m, abort, out_ready,
    input  load_ready, out_valid, out_words, out_round, out_mode, out_last, busy
  );

  modport slave (
    input  load_valid, m, abort, out_ready,
    output load_ready, out_valid, out_words, out_round, out_mode, out_last, busy
  );
endinterface

// File: rtl/blake2_msg_sched.sv
// BLAKE2 message schedule: stores one 16-word block and presents the eight
// SIGMA-permuted words for each column/diagonal step of every round.
module blake2_msg_sched #(
  parameter int WORD_W     = 32,
  parameter int NUM_ROUNDS = 10
) (
  input  logic              clk,
  input  logic              reset,
  blake2_msg_sched_if.slave bus
);

  localparam logic [4:0] LAST_STEP = 5'(2 * NUM_ROUNDS - 1);

  // SIGMA rows packed with entry 0 in the low nibble.
  localparam logic [63:0] SIGMA [10] = '{
    64'hFEDCBA9876543210, 64'h357B20C16DF984AE, 64'h491763EADF250C8B,
    64'h8F04A562EBCD1397, 64'hD386CB1EFA427509, 64'h91EF57D438B0A6C2,
    64'hB8293670A4DEF15C, 64'hA2684F05931CE7BD, 64'h5A417D2C803B9EF6,
    64'h0DC3E9BF5167482A
  };

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_next;
  logic [WORD_W-1:0]   store [16];
  logic [4:0]          step;
  logic [3:0]          rnd, row;
  logic                last, load_fire, advance;
  logic [8*WORD_W-1:0] words;

  assign last      = (step == LAST_STEP);
  assign load_fire = (state == IDLE) && bus.load_valid && !bus.abort;
  assign advance   = (state == RUN) && bus.out_ready && !bus.abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_next = state;
    case (state)
      IDLE: if (load_fire) state_next = RUN;
      RUN:  if (bus.abort || (bus.out_ready && last)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Abort outranks the output handshake; the counter is left at 0 in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           step <= '0;
    else if (load_fire)                  step <= '0;
    else if (state == RUN && bus.abort)  step <= '0;
    else if (advance)                    step <= last ? 5'd0 : step + 5'd1;
  end

  // NOTE: the word store is reset because the outputs must read zero during reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 16; k++) store[k] <= '0;
    end else if (load_fire) begin
      for (int k = 0; k < 16; k++)
        for (int j = 0; j < WORD_W / 8; j++)
          store[k][8*j +: 8] <= bus.m[16*WORD_W-1-k*WORD_W-8*j -: 8];
    end
  end

  // BLAKE2b rounds 10 and 11 reuse SIGMA rows 0 and 1.
  assign rnd = step[4:1];
  assign row = (rnd >= 4'd10) ? rnd - 4'd10 : rnd;

  always_comb begin
    words = '0;
    for (int g = 0; g < 8; g++)
      words[g*WORD_W +: WORD_W] = store[SIGMA[row][{step[0], 3'(g), 2'b00} +: 4]];
  end

  assign bus.load_ready = (state == IDLE);
  assign bus.out_valid  = (state == RUN);
  assign bus.busy       = (state == RUN);
  assign bus.out_words  = words;
  assign bus.out_round  = rnd;
  assign bus.out_mode   = step[0];
  assign bus.out_last   = last;

endmodule

// File: tb/tb_blake2_msg_sched.sv
// Directed bench for blake2_msg_sched: BLAKE2s (32/10) and BLAKE2b (64/12)
// instances checked against an RFC 7693 SIGMA model through a scoreboard queue.
module tb_blake2_msg_sched;

  typedef struct packed {
    logic [511:0] words;
    logic [3:0]   round;
    logic         mode;
    logic         last;
    logic         valid;
  } step_t;

  localparam int SIG [10][16] = '{
    '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
    '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
    '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
    '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
    '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
    '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
    '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
    '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
    '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
    '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}
  };

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  step_t sb [$];

  always #5 clk = ~clk;

  blake2_msg_sched_if #(.WORD_W(32)) bus_a ();
  blake2_msg_sched_if #(.WORD_W(64)) bus_b ();

  blake2_msg_sched #(.WORD_W(32), .NUM_ROUNDS(10)) dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
  blake2_msg_sched #(.WORD_W(64), .NUM_ROUNDS(12)) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic step_t exp_step(input int w, input int nr, input int s, input logic [63:0] st [16]);
    step_t r;
    int rnd, row, md;
    rnd = s / 2;
    row = rnd % 10;
    md  = s % 2;
    r.words = '0;
    for (int g = 0; g < 8; g++) begin
      if (w == 32) r.words[g*32 +: 32] = st[SIG[row][md*8+g]][31:0];
      else         r.words[g*64 +: 64] = st[SIG[row][md*8+g]];
    end
    r.round = 4'(rnd);
    r.mode  = md[0];
    r.last  = (s == 2 * nr - 1);
    r.valid = 1'b1;
    return r;
  endfunction

  function automatic step_t sample_a();
    step_t r;
    r.words = 512'(bus_a.out_words);
    r.round = bus_a.out_round;
    r.mode  = bus_a.out_mode;
    r.last  = bus_a.out_last;
    r.valid = bus_a.out_valid;
    return r;
  endfunction

  function automatic step_t sample_b();
    step_t r;
    r.words = bus_b.out_words;
    r.round = bus_b.out_round;
    r.mode  = bus_b.out_mode;
    r.last  = bus_b.out_last;
    r.valid = bus_b.out_valid;
    return r;
  endfunction

  task automatic compare_step(input string tag, input step_t obs);
    step_t e;
    e = sb.pop_front();
    check({tag, "_words"}, obs.words, e.words);
    check({tag, "_round"}, 512'(obs.round), 512'(e.round));
    check({tag, "_mode"},  512'(obs.mode),  512'(e.mode));
    check({tag, "_last"},  512'(obs.last),  512'(e.last));
    check({tag, "_valid"}, 512'(obs.valid), 512'(e.valid));
  endtask

  // One accepted step per cycle; at step 'inject' a stray load is offered.
  task automatic run_steps(input bit use_b, input int first, input int last_s, input int inject,
                           input logic [63:0] st [16]);
    for (int s = first; s <= last_s; s++) begin
      if (use_b) begin
        bus_b.out_ready  = 1'b1;
        bus_b.load_valid = (s == inject);
        if (s == inject) bus_b.m = '1;
        sb.push_back(exp_step(64, 12, s, st));
        compare_step($sformatf("b_s%0d", s), sample_b());
      end else begin
        bus_a.out_ready  = 1'b1;
        bus_a.load_valid = (s == inject);
        if (s == inject) bus_a.m = '1;
        sb.push_back(exp_step(32, 10, s, st));
        compare_step($sformatf("a_s%0d", s), sample_a());
      end
      tick();
    end
    bus_a.load_valid = 1'b0;
    bus_b.load_valid = 1'b0;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_load_ready"}, 512'(bus_a.load_ready), 512'(1));
    check({tag, "_out_valid"},  512'(bus_a.out_valid),  512'(0));
    check({tag, "_busy"},       512'(bus_a.busy),       512'(0));
    check({tag, "_out_words"},  512'(bus_a.out_words),  512'(0));
    check({tag, "_out_round"},  512'(bus_a.out_round),  512'(0));
    check({tag, "_out_mode"},   512'(bus_a.out_mode),   512'(0));
    check({tag, "_out_last"},   512'(bus_a.out_last),   512'(0));
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_load_ready"}, 512'(bus_a.load_ready), 512'(1));
    check({tag, "_out_valid"},  512'(bus_a.out_valid),  512'(0));
    check({tag, "_busy"},       512'(bus_a.busy),       512'(0));
  endtask

  task automatic load_a(input logic [511:0] mm);
    bus_a.m          = mm;
    bus_a.load_valid = 1'b1;
    tick();
    bus_a.load_valid = 1'b0;
  endtask

  logic [63:0]   st_k [16];
  logic [63:0]   st_b8 [16];
  logic [511:0]  m_k32, m_b8;
  logic [1023:0] m_k64;
  step_t         held;

  initial begin
    bus_a.load_valid = 1'b0; bus_a.abort = 1'b0; bus_a.out_ready = 1'b0; bus_a.m = '0;
    bus_b.load_valid = 1'b0; bus_b.abort = 1'b0; bus_b.out_ready = 1'b0; bus_b.m = '0;

    // Word k = k: its least significant byte sits at the MSB end of its slot.
    m_k32 = '0;
    m_k64 = '0;
    m_b8  = '0;
    for (int k = 0; k < 16; k++) begin
      st_k[k] = 64'(k);
      m_k32[511 - 32*k -: 32]  = 32'(k) << 24;
      m_k64[1023 - 64*k -: 64] = 64'(k) << 56;
      st_b8[k] = {32'h0, 8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
    end
    for (int i = 0; i < 64; i++) m_b8[511 - 8*i -: 8] = 8'(i);

    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    #1;
    check_reset_a("por");
    tick();
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();

    // Full BLAKE2s block with a stray load offered mid-block.
    load_a(m_k32);
    check("first_valid", 512'(bus_a.out_valid), 512'(1));
    check("first_busy",  512'(bus_a.busy),       512'(1));
    check("first_ready", 512'(bus_a.load_ready), 512'(0));
    check("first_words", 512'(bus_a.out_words), exp_step(32, 10, 0, st_k).words);
    run_steps(1'b0, 0, 19, 2, st_k);
    check_idle_a("after_last");

    // Byte order, backpressure at step 5, abort at step 7.
    load_a(m_b8);
    check("byte_w0", 512'(bus_a.out_words[31:0]), 512'(32'h03020100));
    run_steps(1'b0, 0, 0, -1, st_b8);
    check("byte_w15", 512'(bus_a.out_words[255:224]), 512'(32'h3F3E3D3C));
    run_steps(1'b0, 1, 4, -1, st_b8);
    bus_a.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(exp_step(32, 10, 5, st_b8));
      held = sample_a();
      compare_step($sformatf("hold%0d", i), held);
      tick();
    end
    run_steps(1'b0, 5, 6, -1, st_b8);
    bus_a.abort     = 1'b1;
    bus_a.out_ready = 1'b1;
    sb.push_back(exp_step(32, 10, 7, st_b8));
    compare_step("abort_s7", sample_a());
    tick();
    bus_a.abort = 1'b0;
    check_idle_a("after_abort");
    check("abort_round", 512'(bus_a.out_round), 512'(0));

    // Abort in IDLE blocks a simultaneous load.
    bus_a.abort      = 1'b1;
    bus_a.load_valid = 1'b1;
    bus_a.m          = m_k32;
    tick();
    bus_a.abort      = 1'b0;
    bus_a.load_valid = 1'b0;
    check_idle_a("idle_abort");

    // Reload restarts at step 0; reset lands at step 4.
    load_a(m_k32);
    run_steps(1'b0, 0, 3, 2, st_k);
    bus_a.out_ready = 1'b0;
    sb.push_back(exp_step(32, 10, 4, st_k));
    compare_step("pre_reset_s4", sample_a());
    #2;
    rst_a = 1'b1;
    #1;
    check_reset_a("mid_reset");
    tick();
    rst_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_reset_a($sformatf("post_reset%0d", i));
    end

    // BLAKE2b: 12 rounds, rows 10 and 11 wrap to rows 0 and 1.
    bus_b.m          = m_k64;
    bus_b.load_valid = 1'b1;
    tick();
    bus_b.load_valid = 1'b0;
    check("b_first_valid", 512'(bus_b.out_valid), 512'(1));
    run_steps(1'b1, 0, 19, -1, st_k);
    for (int s = 20; s <= 21; s++) begin
      check($sformatf("b_wrap%0d", s), bus_b.out_words, exp_step(64, 12, s - 20, st_k).words);
      run_steps(1'b1, s, s, -1, st_k);
    end
    run_steps(1'b1, 22, 23, -1, st_k);
    check("b_after_ready", 512'(bus_b.load_ready), 512'(1));
    check("b_after_valid", 512'(bus_b.out_valid),  512'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
